// File: rtl/ccr_unit_pkg.sv
// Shared condition-code definitions: flag-op classes and CCR bit positions
// used by both the CCR producer and the branch-condition logic.
package ccr_unit_pkg;

  typedef enum logic [1:0] {
    FOP_ADD   = 2'd0,
    FOP_ADC   = 2'd1,
    FOP_SUB   = 2'd2,
    FOP_LOGIC = 2'd3
  } fop_e;

  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_C = 1;
  localparam int CCR_V = 0;

endpackage

// File: rtl/ccr_flag_calc.sv
// Combinational N/Z/C/V evaluation for one flag-setting op class.
module ccr_flag_calc
  import ccr_unit_pkg::*;
#(
  parameter int W = 16
) (
  input  fop_e         fop,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [3:0]   flags
);

  logic [W:0]   sum;
  logic [W-1:0] r;
  logic         c;
  logic         v;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    sum = '0;
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (fop)
      FOP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      FOP_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      FOP_SUB: begin
        // Carry out of a + ~b + 1 is the inverted borrow: 1 means a >= b unsigned.
        sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        r   = sum[W-1:0];
        c   = sum[W];
        v   = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      default: begin
        r = a;
      end
    endcase

    flags        = '0;
    flags[CCR_N] = r[W-1];
    flags[CCR_Z] = (r == '0);
    flags[CCR_C] = c;
    flags[CCR_V] = v;
  end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register: one-stage flag pipeline, explicit writes and an
// interrupt shadow stack feeding the branch unit.
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd_valid,
  input  logic [1:0]    upd_fop,
  input  logic [W-1:0]  upd_a,
  input  logic [W-1:0]  upd_b,
  input  logic          flush,
  input  logic          ccr_wr,
  input  logic [3:0]    ccr_wdata,
  input  logic          irq_enter,
  input  logic          irq_ret,
  output logic [3:0]    ccr,
  output logic          ccr_busy,
  output logic [DW-1:0] stk_depth,
  output logic          stk_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fop_e         stg_fop;
  logic [W-1:0] stg_a;
  logic [W-1:0] stg_b;
  logic         stg_valid;
  logic [3:0]   stg_flags;

  logic [3:0]   stack [DEPTH];
  logic [DW-1:0] depth;
  logic [3:0]   ccr_next;
  logic [3:0]   stk_top;
  logic         push_ok;
  logic         pop_ok;
  logic         stk_fault;
  logic         commit_op;

  ccr_flag_calc #(.W(W)) u_flag_calc (
    .fop   (stg_fop),
    .a     (stg_a),
    .b     (stg_b),
    .cin   (ccr[CCR_C]),
    .flags (stg_flags)
  );

  // Simultaneous enter and return cancel each other and are flagged as a fault.
  assign push_ok   = irq_enter && !irq_ret && (depth != DW'(DEPTH));
  assign pop_ok    = irq_ret && !irq_enter && (depth != '0);
  assign stk_fault = (irq_enter && irq_ret) ||
                     (irq_enter && (depth == DW'(DEPTH))) ||
                     (irq_ret && (depth == '0));
  assign commit_op = stg_valid && !flush;
  assign stk_top   = stack[AW'(depth - 1'b1)];

  always_comb begin
    ccr_next = ccr;
    if (pop_ok)         ccr_next = stk_top;
    else if (ccr_wr)    ccr_next = ccr_wdata;
    else if (commit_op) ccr_next = stg_flags;
  end

  // NOTE: sequential state is written only with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ccr       <= '0;
      stg_valid <= 1'b0;
      stg_fop   <= FOP_ADD;
      stg_a     <= '0;
      stg_b     <= '0;
      depth     <= '0;
      stk_err   <= 1'b0;
    end else begin
      ccr       <= ccr_next;
      stg_valid <= upd_valid && !flush;
      if (upd_valid && !flush) begin
        stg_fop <= fop_e'(upd_fop);
        stg_a   <= upd_a;
        stg_b   <= upd_b;
      end
      if (push_ok)     depth <= depth + 1'b1;
      else if (pop_ok) depth <= depth - 1'b1;
      if (stk_fault) stk_err <= 1'b1;
    end
  end

  // NOTE: stack storage has no reset; depth alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) stack[AW'(depth)] <= ccr_next;
  end

  assign ccr_busy  = stg_valid;
  assign stk_depth = depth;

endmodule

// File: tb/tb_ccr_unit.sv
// Directed self-checking bench for ccr_unit (W=8, DEPTH=4) with a
// latency-aware scoreboard for pipelined flag results.
module tb_ccr_unit;
  import ccr_unit_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          upd_valid;
  logic [1:0]    upd_fop;
  logic [W-1:0]  upd_a;
  logic [W-1:0]  upd_b;
  logic          flush;
  logic          ccr_wr;
  logic [3:0]    ccr_wdata;
  logic          irq_enter;
  logic          irq_ret;
  logic [3:0]    ccr;
  logic          ccr_busy;
  logic [DW-1:0] stk_depth;
  logic          stk_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [3:0] exp_q [$];
  int         due_q [$];
  logic [3:0] vals [4] = '{4'h3, 4'h5, 4'hA, 4'hC};

  ccr_unit #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_valid (upd_valid),
    .upd_fop   (upd_fop),
    .upd_a     (upd_a),
    .upd_b     (upd_b),
    .flush     (flush),
    .ccr_wr    (ccr_wr),
    .ccr_wdata (ccr_wdata),
    .irq_enter (irq_enter),
    .irq_ret   (irq_ret),
    .ccr       (ccr),
    .ccr_busy  (ccr_busy),
    .stk_depth (stk_depth),
    .stk_err   (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample 1 ns after the edge and retire due scoreboard entries.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    while (due_q.size() > 0 && due_q[0] == cyc) begin
      check("sb_ccr", {28'd0, ccr}, {28'd0, exp_q.pop_front()});
      void'(due_q.pop_front());
    end
  endtask

  task automatic op(input fop_e fop, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [3:0] exp, input bit track);
    upd_valid = 1'b1;
    upd_fop   = fop;
    upd_a     = a;
    upd_b     = b;
    if (track) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + 2);
    end
  endtask

  task automatic idle();
    upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_fop = '0; upd_a = '0; upd_b = '0;
    flush = 1'b0; ccr_wr = 1'b0; ccr_wdata = '0; irq_enter = 1'b0; irq_ret = 1'b0;
    step(); step();
    check("rst_ccr",   {28'd0, ccr}, 32'h0);
    check("rst_busy",  {31'd0, ccr_busy}, 32'h0);
    check("rst_depth", {29'd0, stk_depth}, 32'h0);
    check("rst_err",   {31'd0, stk_err}, 32'h0);
    rst = 1'b0;
    step();

    // SUB equal operands, then a borrowing SUB
    op(FOP_SUB, 8'h05, 8'h05, 4'b0110, 1); step();
    check("sub_busy", {31'd0, ccr_busy}, 32'h1);
    idle(); step();
    op(FOP_SUB, 8'h00, 8'h01, 4'b1000, 1); step(); idle(); step();

    // Signed overflow, then dependent ADD/ADC chain back to back
    op(FOP_ADD, 8'h7F, 8'h01, 4'b1001, 1); step(); idle(); step();
    op(FOP_ADD, 8'hFF, 8'h01, 4'b0110, 1); step();
    op(FOP_ADC, 8'h00, 8'h00, 4'b0000, 1); step();
    idle(); step(); step();
    op(FOP_LOGIC, 8'h80, 8'h00, 4'b1000, 1); step(); idle(); step();

    // Explicit write beats a pending stage op, which is dropped
    op(FOP_SUB, 8'h05, 8'h05, 4'b0000, 0); step();
    idle(); ccr_wr = 1'b1; ccr_wdata = 4'b1111; step();
    ccr_wr = 1'b0;
    check("wr_prio", {28'd0, ccr}, 32'hF);
    step();
    check("wr_drop", {28'd0, ccr}, 32'hF);

    // Flush discards the op held in the stage
    op(FOP_SUB, 8'h00, 8'h01, 4'b0000, 0); step();
    idle(); flush = 1'b1; step();
    flush = 1'b0;
    check("flush_ccr",  {28'd0, ccr}, 32'hF);
    check("flush_busy", {31'd0, ccr_busy}, 32'h0);
    step();
    check("flush_hold", {28'd0, ccr}, 32'hF);

    // Fill the stack, overflow it, then drain in LIFO order and underflow
    for (int i = 0; i < 4; i++) begin
      ccr_wr = 1'b1; ccr_wdata = vals[i]; irq_enter = 1'b1; step();
    end
    ccr_wr = 1'b0;
    check("push_depth", {29'd0, stk_depth}, 32'd4);
    check("push_noerr", {31'd0, stk_err}, 32'h0);
    step();
    irq_enter = 1'b0;
    check("ovf_depth", {29'd0, stk_depth}, 32'd4);
    check("ovf_err",   {31'd0, stk_err}, 32'h1);
    ccr_wr = 1'b1; ccr_wdata = 4'h0; step(); ccr_wr = 1'b0;
    irq_ret = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step();
      check($sformatf("pop%0d_ccr", i), {28'd0, ccr}, {28'd0, vals[i]});
      check($sformatf("pop%0d_depth", i), {29'd0, stk_depth}, i);
    end
    step();
    irq_ret = 1'b0;
    check("unf_ccr",   {28'd0, ccr}, {28'd0, vals[0]});
    check("unf_depth", {29'd0, stk_depth}, 32'd0);
    check("unf_err",   {31'd0, stk_err}, 32'h1);

    // Push captures the same-cycle committing ADD result
    op(FOP_ADD, 8'h80, 8'h80, 4'b0111, 1); step();
    idle(); irq_enter = 1'b1; step();
    irq_enter = 1'b0;
    check("irqadd_depth", {29'd0, stk_depth}, 32'd1);
    ccr_wr = 1'b1; ccr_wdata = 4'h0; step(); ccr_wr = 1'b0;
    check("irqadd_clr", {28'd0, ccr}, 32'h0);
    irq_ret = 1'b1; step(); irq_ret = 1'b0;
    check("irqadd_ret", {28'd0, ccr}, 32'h7);
    check("irqadd_ret_depth", {29'd0, stk_depth}, 32'd0);

    // Asynchronous reset mid-cycle with an op in the stage
    op(FOP_SUB, 8'h05, 8'h05, 4'b0000, 0); step();
    idle();
    check("arst_pre_busy", {31'd0, ccr_busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_ccr",   {28'd0, ccr}, 32'h0);
    check("arst_busy",  {31'd0, ccr_busy}, 32'h0);
    check("arst_depth", {29'd0, stk_depth}, 32'd0);
    check("arst_err",   {31'd0, stk_err}, 32'h0);
    step();
    rst = 1'b0;
    step(); step();
    check("arst_nocommit", {28'd0, ccr}, 32'h0);
    check("sb_drained", due_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
